// File: rtl/unity_ecc_pkg.sv
// Shared GF(2^8) definitions for the unity ECC family: field width, primitive
// polynomial 0x11D (alpha = 0x02), alpha^i for symbol positions 0..9, the
// parity-solve inverse constant, and codeword/data geometry.
package unity_ecc_pkg;

  localparam int unsigned GF_W      = 8;
  localparam logic [GF_W:0] GF_POLY = 9'h11D;
  localparam int unsigned SYM_CNT   = 10;
  localparam int unsigned DATA_SYMS = 8;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned CW_W      = 80;

  typedef logic [GF_W-1:0] gf_t;

  // Shift-and-add GF multiply; with one operand constant it folds to XORs.
  function automatic gf_t gf_mul(input gf_t a, input gf_t b);
    gf_t acc;
    gf_t sh;
    acc = '0;
    sh  = a;
    for (int unsigned k = 0; k < GF_W; k++) begin
      if (b[k]) acc ^= sh;
      sh = {sh[GF_W-2:0], 1'b0} ^ (sh[GF_W-1] ? GF_POLY[GF_W-1:0] : '0);
    end
    return acc;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128.
  function automatic gf_t gf_inv(input gf_t a);
    gf_t sq;
    gf_t acc;
    sq  = a;
    acc = 8'h01;
    for (int unsigned k = 1; k < GF_W; k++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // alpha^i, i = 0..9
  localparam gf_t ALPHA_POW [SYM_CNT] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                          8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};

  // inv(alpha^8 ^ alpha^9), used to solve for parity symbol c9
  localparam gf_t PAR_INV = gf_inv(ALPHA_POW[8] ^ ALPHA_POW[9]);

endpackage

// File: rtl/unity_gf_cmul.sv
// Combinational GF(2^8) multiply by a fixed constant.
module unity_gf_cmul
  import unity_ecc_pkg::*;
#(
  parameter gf_t CONST = 8'h01
) (
  input  logic [GF_W-1:0] a,
  output logic [GF_W-1:0] y
);

  // Constant operand reduces the multiply to a fixed XOR network
  always_comb y = gf_mul(a, CONST);

endmodule

// File: rtl/unity_encoder.sv
// Two-stage systematic encoder: 64-bit payload plus two GF(2^8) parity
// symbols (c8, c9) chosen so both decoder syndromes S0 and S1 are zero.
// Optional feature macro: UNITY_ENC_ERR_INJ_EN adds err_mask/err_inj for
// XOR-ing a test pattern into the next accepted word's codeword.
module unity_encoder
  import unity_ecc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CW_W-1:0]   codeword_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       enc_count
`ifdef UNITY_ENC_ERR_INJ_EN
  ,
  input  logic [CW_W-1:0]   err_mask,
  input  logic              err_inj
`endif
);

  gf_t d_sym  [DATA_SYMS];
  gf_t d_prod [DATA_SYMS];
  gf_t a_in, b_in;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  gf_t               s1_a, s1_b;
`ifdef UNITY_ENC_ERR_INJ_EN
  logic [CW_W-1:0]   s1_mask;
`endif

  logic            s1_advance;
  logic            accept;
  gf_t             a8_term, c9_num, c8, c9;
  logic [CW_W-1:0] cw_next;

  assign s1_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready;

  for (genvar i = 0; i < DATA_SYMS; i++) begin : g_wsum
    assign d_sym[i] = data_in[GF_W*i +: GF_W];
    unity_gf_cmul #(.CONST(ALPHA_POW[i])) u_mul (.a(d_sym[i]), .y(d_prod[i]));
  end

  // Plain and alpha-weighted symbol sums of the incoming payload
  always_comb begin
    a_in = '0;
    b_in = '0;
    for (int unsigned k = 0; k < DATA_SYMS; k++) begin
      a_in ^= d_sym[k];
      b_in ^= d_prod[k];
    end
  end

  // Stage 1: capture payload and partial sums when a word is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
`ifdef UNITY_ENC_ERR_INJ_EN
      s1_mask  <= '0;
`endif
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_data <= data_in;
        s1_a    <= a_in;
        s1_b    <= b_in;
`ifdef UNITY_ENC_ERR_INJ_EN
        s1_mask <= err_inj ? err_mask : '0;
`endif
      end
    end
  end

  // c9 = (B ^ alpha^8*A) * inv(alpha^8 ^ alpha^9); c8 = A ^ c9
  unity_gf_cmul #(.CONST(ALPHA_POW[8])) u_a8  (.a(s1_a),   .y(a8_term));
  assign c9_num = s1_b ^ a8_term;
  unity_gf_cmul #(.CONST(PAR_INV))      u_inv (.a(c9_num), .y(c9));
  assign c8 = s1_a ^ c9;

  // Assemble the stage-2 codeword, applying any latched injection mask
  always_comb begin
    cw_next = {c9, c8, s1_data};
`ifdef UNITY_ENC_ERR_INJ_EN
    cw_next ^= s1_mask;
`endif
  end

  // Stage 2: output register, held while the sink stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      codeword_out <= '0;
    end else if (s1_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) codeword_out <= cw_next;
    end
  end

  // Saturating count of delivered codewords
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enc_count <= '0;
    end else if (out_valid && out_ready && (enc_count != '1)) begin
      enc_count <= enc_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_unity_encoder.sv
// Directed + random bench for unity_encoder with a reference-model scoreboard.
module tb_unity_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] data_in;
  logic        in_valid;
  logic        in_ready;
  logic [79:0] codeword_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] enc_count;
`ifdef UNITY_ENC_ERR_INJ_EN
  logic [79:0] err_mask;
  logic        err_inj;
`endif

  always #5 clk = ~clk;

  unity_encoder dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .codeword_out(codeword_out), .out_valid(out_valid),
    .out_ready(out_ready), .enc_count(enc_count)
`ifdef UNITY_ENC_ERR_INJ_EN
    , .err_mask(err_mask), .err_inj(err_inj)
`endif
  );

  typedef struct {
    logic [79:0] cw;
    logic [63:0] data;
    logic        inj;
  } exp_t;

  exp_t        sb [$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_cnt;
  logic        hold_pending;
  logic [79:0] held_cw;
  logic [7:0]  apow [10];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  // Reference: search the c9 that zeroes S1 once c8 = A ^ c9 zeroes S0
  function automatic logic [79:0] encode_ref(input logic [63:0] d);
    logic [7:0] a, b, c8, c9;
    a = 8'h00; b = 8'h00; c8 = 8'h00; c9 = 8'h00;
    for (int i = 0; i < 8; i++) begin
      a ^= d[8*i +: 8];
      b ^= gmul(apow[i], d[8*i +: 8]);
    end
    for (int v = 0; v < 256; v++) begin
      c9 = 8'(v);
      c8 = a ^ c9;
      if ((b ^ gmul(apow[8], c8) ^ gmul(apow[9], c9)) == 8'h00) break;
    end
    return {c9, c8, d};
  endfunction

  // Single-symbol-correcting decoder model
  function automatic void decode(input logic [79:0] cw, output logic [63:0] d,
                                 output logic corr, output logic bad);
    logic [7:0]  s0, s1;
    logic [79:0] fixed;
    s0 = 8'h00; s1 = 8'h00;
    for (int i = 0; i < 10; i++) begin
      s0 ^= cw[8*i +: 8];
      s1 ^= gmul(apow[i], cw[8*i +: 8]);
    end
    d = cw[63:0]; corr = 1'b0; bad = 1'b0;
    if (s0 != 8'h00 || s1 != 8'h00) begin
      bad = 1'b1;
      if (s0 != 8'h00) begin
        for (int j = 0; j < 10; j++) begin
          if (gmul(s0, apow[j]) == s1) begin
            fixed = cw;
            fixed[8*j +: 8] ^= s0;
            d = fixed[63:0]; corr = 1'b1; bad = 1'b0;
          end
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic deliver();
    exp_t        e;
    logic [63:0] d;
    logic        corr, bad;
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL spurious_word observed=%h expected=none", codeword_out);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("codeword", codeword_out, e.cw);
      decode(codeword_out, d, corr, bad);
      chk("dec_data", {16'h0, d}, {16'h0, e.data});
      chk("dec_flags", {78'h0, corr, bad}, {78'h0, e.inj, 1'b0});
    end
  endtask

  // Inputs are already driven; sample handshakes, then advance one clock.
  task automatic tick(output logic acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    chk("enc_count", {48'h0, enc_count}, {48'h0, exp_cnt});
    if (hold_pending) begin
      chk("hold_valid", {79'h0, out_valid}, 80'd1);
      chk("hold_word", codeword_out, held_cw);
    end
    hold_pending = out_valid && !out_ready;
    held_cw = codeword_out;
    if (out_valid && out_ready) begin
      deliver();
      if (exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
    end
    if (acc) begin
      e.data = data_in;
`ifdef UNITY_ENC_ERR_INJ_EN
      e.inj = err_inj;
      e.cw  = encode_ref(data_in) ^ (err_inj ? err_mask : 80'h0);
`else
      e.inj = 1'b0;
      e.cw  = encode_ref(data_in);
`endif
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", {79'h0, out_valid}, 80'd0);
    chk("rst_codeword", codeword_out, 80'h0);
    chk("rst_count", {48'h0, enc_count}, 80'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {79'h0, in_ready}, 80'd1);
    sb.delete();
    hold_pending = 1'b0;
    exp_cnt = 32'h0;
  endtask

  task automatic drain(input int budget);
    logic acc;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < budget && sb.size() != 0; c++) tick(acc);
    chk("drain_empty", 80'(sb.size()), 80'd0);
  endtask

  initial begin
    logic        acc;
    logic        pend;
    int          idx;
    int          nacc;
    logic [63:0] w [4];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
`ifdef UNITY_ENC_ERR_INJ_EN
    err_mask = '0; err_inj = 1'b0;
`endif
    hold_pending = 1'b0; exp_cnt = 32'h0;
    apow[0] = 8'h01;
    for (int i = 1; i < 10; i++) apow[i] = gmul(apow[i-1], 8'h02);
    @(negedge clk);
    do_reset();

    // Zero word: two-cycle latency, all-zero codeword, count of one
    data_in = 64'h0; in_valid = 1'b1; out_ready = 1'b1;
    tick(acc);
    in_valid = 1'b0;
    chk("lat_edge1_valid", {79'h0, out_valid}, 80'd0);
    tick(acc);
    chk("lat_edge2_valid", {79'h0, out_valid}, 80'd1);
    chk("zero_codeword", codeword_out, 80'h0);
    tick(acc);
    chk("zero_count", {48'h0, enc_count}, 80'd1);

    // Back-to-back input against a stalled sink
    for (int i = 0; i < 4; i++) w[i] = {$urandom, $urandom};
    idx = 0; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      data_in = w[idx & 3]; in_valid = (idx < 4);
      tick(acc);
      if (acc) idx++;
    end
    chk("stall_accepted", 80'(idx), 80'd2);
    chk("stall_in_ready", {79'h0, in_ready}, 80'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && (idx < 4 || sb.size() != 0); c++) begin
      data_in = w[idx & 3]; in_valid = (idx < 4);
      tick(acc);
      if (acc) idx++;
    end
    chk("stall_all_sent", 80'(idx), 80'd4);
    drain(20);

    // Random payloads under random valid/ready
    nacc = 0; pend = 1'b0;
    for (int c = 0; c < 20000 && (nacc < 1000 || sb.size() != 0); c++) begin
      if (!pend) begin
        in_valid = (nacc < 1000) && ($urandom_range(0, 3) != 0);
        data_in  = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      pend = in_valid && !acc;
      if (acc) nacc++;
    end
    chk("random_accepted", 80'(nacc), 80'd1000);
    drain(20);

    // Reset with two words in flight
    out_ready = 1'b0; in_valid = 1'b1;
    data_in = 64'h0123_4567_89AB_CDEF; tick(acc);
    data_in = 64'hFEDC_BA98_7654_3210; tick(acc);
    chk("flight_out_valid", {79'h0, out_valid}, 80'd1);
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) tick(acc);
    chk("post_rst_out_valid", {79'h0, out_valid}, 80'd0);
    chk("post_rst_count", {48'h0, enc_count}, 80'd0);

    // Saturation from a preloaded count
    force dut.enc_count = 32'hFFFF_FFFE;
    #1;
    release dut.enc_count;
    exp_cnt = 32'hFFFF_FFFE;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = {$urandom, $urandom};
      tick(acc);
    end
    drain(20);
    tick(acc);
    chk("sat_count", {48'h0, enc_count}, {48'h0, 32'hFFFF_FFFF});

`ifdef UNITY_ENC_ERR_INJ_EN
    // Injected parity-symbol error on zero data
    data_in = 64'h0; in_valid = 1'b1; out_ready = 1'b1;
    err_mask = {8'h00, 8'hA3, 64'h0}; err_inj = 1'b1;
    tick(acc);
    err_inj = 1'b0; err_mask = '0; in_valid = 1'b0;
    tick(acc);
    chk("inj_codeword", codeword_out, {8'h00, 8'hA3, 64'h0});
    drain(20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
